// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcodes, NZCV flag layout and the result buffer depth.
package alu_pkg;

  typedef enum logic [2:0] {
    OP_ADD  = 3'd0,
    OP_SUB  = 3'd1,
    OP_AND  = 3'd2,
    OP_OR   = 3'd3,
    OP_XOR  = 3'd4,
    OP_SHL  = 3'd5,
    OP_SHR  = 3'd6,
    OP_PASS = 3'd7
  } alu_op_e;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  localparam int RESULT_BUF_DEPTH = 2;

  typedef struct packed {
    logic n;
    logic z;
    logic c;
    logic v;
  } nzcv_t;

endpackage

// File: rtl/alu_skid_buf.sv
// Two-entry FIFO of {y, nzcv} used as the result stage skid buffer.
// Valid/ready: push_i and pop_i are already qualified handshakes from the caller.
module alu_skid_buf
  import alu_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int DEPTH = RESULT_BUF_DEPTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] y_i,
  input  nzcv_t            flags_i,
  output logic [1:0]       count_o,
  output logic [WIDTH-1:0] y_o,
  output nzcv_t            flags_o
);

  generate
    if (DEPTH != 2) begin : g_depth_check
      $error("alu_skid_buf supports DEPTH == 2 only");
    end
  endgenerate

  logic [WIDTH-1:0] y_q [2];
  nzcv_t            f_q [2];
  logic             wr_ptr_q;
  logic             rd_ptr_q;
  logic [1:0]       count_q;
  logic [1:0]       count_d;

  always_comb begin
    count_d = count_q;
    case ({push_i, pop_i})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q  <= 2'd0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        y_q[i] <= '0;
        f_q[i] <= '0;
      end
    end else begin
      if (push_i) begin
        y_q[wr_ptr_q] <= y_i;
        f_q[wr_ptr_q] <= flags_i;
        wr_ptr_q      <= ~wr_ptr_q;
      end
      if (pop_i) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      count_q <= count_d;
    end
  end

  assign count_o = count_q;
  assign y_o     = y_q[rd_ptr_q];
  assign flags_o = f_q[rd_ptr_q];

endmodule

// File: rtl/alu_result_stage.sv
// Registered ALU write-back stage: skid-buffered result path plus the NZCV status register.
// Define ALU_STICKY_OVERFLOW_EN to add the ov_sticky output.
module alu_result_stage
  import alu_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int DEPTH = RESULT_BUF_DEPTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_y,
  input  logic             in_cout,
  input  logic             in_overflow,
  input  logic             in_negative,
  input  logic             in_zero,
  input  logic             in_flag_we,
  input  logic             clr_status,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_y,
  output logic [3:0]       out_flags,
  output logic [3:0]       status_nzcv,
  output logic             carry_q
`ifdef ALU_STICKY_OVERFLOW_EN
  ,
  output logic             ov_sticky
`endif
);

  // Valid/ready: a transfer happens on a side only when valid and ready are both
  // high at the rising edge; in_ready depends on registered occupancy alone.
  logic       push;
  logic       pop;
  logic [1:0] count;
  nzcv_t      in_flags;
  nzcv_t      head_flags;
  nzcv_t      status_q;
  nzcv_t      status_d;

  assign in_flags  = '{n: in_negative, z: in_zero, c: in_cout, v: in_overflow};
  assign in_ready  = (count != 2'd2);
  assign out_valid = (count != 2'd0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  alu_skid_buf #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH)
  ) u_buf (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push),
    .pop_i   (pop),
    .y_i     (in_y),
    .flags_i (in_flags),
    .count_o (count),
    .y_o     (out_y),
    .flags_o (head_flags)
  );

  assign out_flags = head_flags;

  // Flags commit at push time so carry_q is ready for the very next operation.
  always_comb begin
    status_d = status_q;
    if (push && in_flag_we) begin
      status_d = in_flags;
    end else if (clr_status) begin
      status_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      status_q <= '0;
    end else begin
      status_q <= status_d;
    end
  end

  assign status_nzcv[FLAG_N] = status_q.n;
  assign status_nzcv[FLAG_Z] = status_q.z;
  assign status_nzcv[FLAG_C] = status_q.c;
  assign status_nzcv[FLAG_V] = status_q.v;
  assign carry_q             = status_q.c;

`ifdef ALU_STICKY_OVERFLOW_EN
  logic sticky_q;
  logic sticky_d;

  always_comb begin
    sticky_d = sticky_q;
    if (push && in_flag_we && in_overflow) begin
      sticky_d = 1'b1;
    end else if (clr_status) begin
      sticky_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sticky_q <= 1'b0;
    end else begin
      sticky_q <= sticky_d;
    end
  end

  assign ov_sticky = sticky_q;
`endif

endmodule

// File: tb/tb_alu_result_stage.sv
// Self-checking bench for alu_result_stage: scenario tasks plus an expected-result queue.
module tb_alu_result_stage;

  localparam int WIDTH = 4;
  localparam int W     = WIDTH + 4;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_y;
  logic             in_cout;
  logic             in_overflow;
  logic             in_negative;
  logic             in_zero;
  logic             in_flag_we;
  logic             clr_status;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_y;
  logic [3:0]       out_flags;
  logic [3:0]       status_nzcv;
  logic             carry_q;
`ifdef ALU_STICKY_OVERFLOW_EN
  logic             ov_sticky;
`endif

  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q[$];

  alu_result_stage #(.WIDTH(WIDTH)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_y        (in_y),
    .in_cout     (in_cout),
    .in_overflow (in_overflow),
    .in_negative (in_negative),
    .in_zero     (in_zero),
    .in_flag_we  (in_flag_we),
    .clr_status  (clr_status),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_y       (out_y),
    .out_flags   (out_flags),
    .status_nzcv (status_nzcv),
    .carry_q     (carry_q)
`ifdef ALU_STICKY_OVERFLOW_EN
    ,
    .ov_sticky   (ov_sticky)
`endif
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard ----------------
  // Handshakes resolve at the next rising edge; inputs are stable at the falling edge.
  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid && out_ready) begin
        logic [W-1:0] exp;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL sb_unexpected_pop got y=%h flags=%b, expected nothing", out_y, out_flags);
        end else begin
          exp = exp_q.pop_front();
          if ({out_y, out_flags} !== exp) begin
            errors++;
            $display("FAIL sb_data got y=%h flags=%b expected y=%h flags=%b",
                     out_y, out_flags, exp[W-1:4], exp[3:0]);
          end
        end
      end
      if (in_valid && in_ready)
        exp_q.push_back({in_y, in_negative, in_zero, in_cout, in_overflow});
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    in_valid    = 1'b0;
    in_y        = '0;
    in_cout     = 1'b0;
    in_overflow = 1'b0;
    in_negative = 1'b0;
    in_zero     = 1'b0;
    in_flag_we  = 1'b0;
    clr_status  = 1'b0;
  endtask

  task automatic set_in(input logic [3:0] y, input logic [3:0] nzcv, input logic we);
    in_valid = 1'b1;
    in_y     = y;
    {in_negative, in_zero, in_cout, in_overflow} = nzcv;
    in_flag_we = we;
  endtask

  // Presents one result and returns #1 after the edge that accepted it.
  task automatic send(input logic [3:0] y, input logic [3:0] nzcv, input logic we);
    int waited;
    waited = 0;
    set_in(y, nzcv, we);
    @(negedge clk);
    while (!in_ready && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL send_timeout in_ready=%b after %0d cycles, expected 1", in_ready, waited);
    end
    step();
    in_valid   = 1'b0;
    in_flag_we = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    drive_idle();
    out_ready = 1'b1;
    rst_n     = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_hs in_ready=%b out_valid=%b expected 1/0", in_ready, out_valid);
    end
    checks++;
    if (out_y !== 4'h0 || out_flags !== 4'h0) begin
      errors++;
      $display("FAIL reset_data out_y=%h out_flags=%b expected 0/0", out_y, out_flags);
    end
    checks++;
    if (status_nzcv !== 4'h0 || carry_q !== 1'b0) begin
      errors++;
      $display("FAIL reset_status status=%b carry=%b expected 0000/0", status_nzcv, carry_q);
    end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_first_push();
    send(4'b0010, 4'b0000, 1'b1);
    checks++;
    if (out_valid !== 1'b1 || out_y !== 4'b0010) begin
      errors++;
      $display("FAIL first_push out_valid=%b out_y=%b expected 1/0010", out_valid, out_y);
    end
    checks++;
    if (status_nzcv !== 4'b0000 || carry_q !== 1'b0) begin
      errors++;
      $display("FAIL first_status status=%b carry=%b expected 0000/0", status_nzcv, carry_q);
    end
    step();
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b0;
    set_in(4'b0111, 4'b0000, 1'b0);
    step();
    checks++;
    if (in_ready !== 1'b1 || out_y !== 4'b0111) begin
      errors++;
      $display("FAIL b2b_one in_ready=%b out_y=%b expected 1/0111", in_ready, out_y);
    end
    set_in(4'b1111, 4'b1000, 1'b0);
    step();
    checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_y !== 4'b0111) begin
      errors++;
      $display("FAIL b2b_full in_ready=%b out_valid=%b out_y=%b expected 0/1/0111",
               in_ready, out_valid, out_y);
    end
    set_in(4'b0110, 4'b0000, 1'b0);
    step();
    checks++;
    if (in_ready !== 1'b0 || out_y !== 4'b0111) begin
      errors++;
      $display("FAIL b2b_hold in_ready=%b out_y=%b expected 0/0111", in_ready, out_y);
    end
    out_ready = 1'b1;
    step();
    checks++;
    if (in_ready !== 1'b1 || out_y !== 4'b1111) begin
      errors++;
      $display("FAIL b2b_pop1 in_ready=%b out_y=%b expected 1/1111", in_ready, out_y);
    end
    step();
    checks++;
    if (out_valid !== 1'b1 || out_y !== 4'b0110) begin
      errors++;
      $display("FAIL b2b_pushpop out_valid=%b out_y=%b expected 1/0110", out_valid, out_y);
    end
    in_valid = 1'b0;
    step();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL b2b_drain out_valid=%b expected 0", out_valid);
    end
  endtask

  task automatic test_carry();
    send(4'h3, 4'b0010, 1'b1);
    checks++;
    if (carry_q !== 1'b1) begin
      errors++;
      $display("FAIL carry_set carry_q=%b expected 1", carry_q);
    end
    send(4'h4, 4'b0000, 1'b0);
    checks++;
    if (carry_q !== 1'b1 || status_nzcv !== 4'b0010) begin
      errors++;
      $display("FAIL carry_hold carry=%b status=%b expected 1/0010", carry_q, status_nzcv);
    end
  endtask

  task automatic test_clear();
    clr_status = 1'b1;
    send(4'h9, 4'b1011, 1'b1);
    clr_status = 1'b0;
    checks++;
    if (status_nzcv !== 4'b1011) begin
      errors++;
      $display("FAIL clr_vs_push status=%b expected 1011", status_nzcv);
    end
    clr_status = 1'b1;
    step();
    clr_status = 1'b0;
    checks++;
    if (status_nzcv !== 4'b0000 || carry_q !== 1'b0) begin
      errors++;
      $display("FAIL clr_alone status=%b carry=%b expected 0000/0", status_nzcv, carry_q);
    end
  endtask

  task automatic test_async_reset();
    repeat (3) step();
    out_ready = 1'b0;
    send(4'h5, 4'b1100, 1'b1);
    send(4'h6, 4'b1100, 1'b1);
    checks++;
    if (in_ready !== 1'b0 || status_nzcv !== 4'b1100) begin
      errors++;
      $display("FAIL arst_setup in_ready=%b status=%b expected 0/1100", in_ready, status_nzcv);
    end
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || status_nzcv !== 4'b0000) begin
      errors++;
      $display("FAIL arst_immediate out_valid=%b in_ready=%b status=%b expected 0/1/0000",
               out_valid, in_ready, status_nzcv);
    end
    out_ready = 1'b1;
    step();
    rst_n = 1'b1;
    step();
  endtask

`ifdef ALU_STICKY_OVERFLOW_EN
  task automatic test_sticky();
    send(4'h1, 4'b0001, 1'b1);
    send(4'h2, 4'b0000, 1'b1);
    checks++;
    if (status_nzcv[0] !== 1'b0 || ov_sticky !== 1'b1) begin
      errors++;
      $display("FAIL sticky_set V=%b ov_sticky=%b expected 0/1", status_nzcv[0], ov_sticky);
    end
    clr_status = 1'b1;
    step();
    clr_status = 1'b0;
    checks++;
    if (ov_sticky !== 1'b0) begin
      errors++;
      $display("FAIL sticky_clr ov_sticky=%b expected 0", ov_sticky);
    end
  endtask
`endif

  task automatic test_random();
    logic [3:0] exp_status;
    logic       acc;
    exp_status = status_nzcv;
    for (int i = 0; i < 200; i++) begin
      in_valid   = 1'($urandom_range(0, 1));
      in_y       = 4'($urandom_range(0, 15));
      {in_negative, in_zero, in_cout, in_overflow} = 4'($urandom_range(0, 15));
      in_flag_we = 1'($urandom_range(0, 1));
      clr_status = ($urandom_range(0, 7) == 0);
      out_ready  = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      acc = in_valid && in_ready;
      if (acc && in_flag_we)
        exp_status = {in_negative, in_zero, in_cout, in_overflow};
      else if (clr_status)
        exp_status = 4'b0000;
      step();
      checks++;
      if (status_nzcv !== exp_status || carry_q !== exp_status[1]) begin
        errors++;
        $display("FAIL rand_status cycle %0d status=%b carry=%b expected %b", i,
                 status_nzcv, carry_q, exp_status);
      end
    end
    drive_idle();
  endtask

  task automatic test_drain();
    int waited;
    waited    = 0;
    out_ready = 1'b1;
    while (out_valid && waited < 10) begin
      step();
      waited++;
    end
    step();
    checks++;
    if (exp_q.size() != 0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL drain left=%0d out_valid=%b expected 0/0", exp_q.size(), out_valid);
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_first_push();
    test_back_to_back();
    test_carry();
    test_clear();
    test_async_reset();
`ifdef ALU_STICKY_OVERFLOW_EN
    test_sticky();
`endif
    test_random();
    test_drain();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_result_stage.md
Name: alu_result_stage

Overview:
- Registered write-back stage directly downstream of the combinational alu.
- Captures y and the four flags through a valid/ready handshake into a 2-entry skid buffer, so the alu's producer never stalls on a bubble.
- Maintains the architectural NZCV status register and feeds the registered carry back as the alu's cin for chained multi-word operations.

Parameters:
- WIDTH, 4, data width of y; matches the alu's width parameter.
- DEPTH, 2, skid buffer entries; only 2 is supported, and elaboration fails otherwise.

Ports:
- clk  input  1  single clock, rising edge
- rst_n  input  1  asynchronous, active-low reset
- in_valid  input  1  alu result valid this cycle
- in_ready  output  1  stage can accept a result
- in_y  input  WIDTH  alu y
- in_cout  input  1  alu cout
- in_overflow  input  1  alu overflow
- in_negative  input  1  alu negative
- in_zero  input  1  alu zero
- in_flag_we  input  1  accepted result updates the status register
- clr_status  input  1  synchronous clear of the status register
- out_valid  output  1  buffered result available
- out_ready  input  1  consumer accepts the result
- out_y  output  WIDTH  head-entry result
- out_flags  output  4  head-entry flags, {N,Z,C,V}
- status_nzcv  output  4  architectural status register, {N,Z,C,V}
- carry_q  output  1  status C bit; drives the alu's cin

Behaviour:
- Reset (rst_n low, asynchronous):
  - count=0, pointers=0, in_ready=1, out_valid=0, out_y=0, out_flags=0, status_nzcv=0, carry_q=0.
  - Deassertion is synchronised to clk by the enclosing design.
- Handshakes:
  - Push on in_valid & in_ready; pop on out_valid & out_ready.
  - in_ready = (count < 2), from registered state only, with no combinational path from out_ready.
  - out_valid = (count != 0).
  - out_y and out_flags present the head entry and stay stable while out_valid & !out_ready.
- Latency: a result pushed in cycle t is visible on out_* in cycle t+1 when the buffer was empty.
- Buffer boundaries:
  - Empty with simultaneous push and pop: not possible in the same cycle, because out_valid=0.
  - count=1 with push and pop together: count stays 1 and the head advances to the new entry.
  - Full (count=2): in_ready=0 and no push occurs; a pop that cycle makes in_ready=1 in the next cycle.
  - Pointers are 1 bit and wrap modulo 2.
- Status register:
  - Updated at push time, not pop time: on a push with in_flag_we=1, status_nzcv <= {in_negative, in_zero, in_cout, in_overflow} at the next edge.
  - carry_q is valid for the next alu operation one cycle after the push.
  - A push with in_flag_we=0 leaves status unchanged.
  - clr_status=1 sets status_nzcv to 0 at the next edge. If a flag-writing push happens in the same cycle, the push value wins.
- Reset mid-operation: buffered entries are discarded and no pop is signalled.

Optional Feature:
- Macro: ALU_STICKY_OVERFLOW_EN.
- Defined:
  - Adds output ov_sticky (1 bit, reset 0).
  - Set on any push with in_flag_we=1 and in_overflow=1.
  - Cleared only by clr_status; set wins over clear in the same cycle.
  - status V bit behaviour is unchanged.
- Undefined: the port and register are absent.

Decomposition:
- Shared package alu_pkg:
  - Flag index constants FLAG_N=3, FLAG_Z=2, FLAG_C=1, FLAG_V=0.
  - typedef nzcv_t (4-bit packed struct n,z,c,v).
  - Constant RESULT_BUF_DEPTH=2.
  - Placed alongside the existing ops opcode constants.
- One sub-module, alu_skid_buf:
  - Parameterised 2-entry FIFO of {y, nzcv_t} with count and pointers.
  - The status register and optional sticky logic stay in alu_result_stage.

Test Plan:
- Reset, then push y=4'b0010 with flags N=0,Z=0,C=0,V=0 and in_flag_we=1 -> out_valid=1 next cycle, out_y=4'b0010, status_nzcv=4'b0000, carry_q=0.
- Hold out_ready=0 and push 3'd results 4'b0111, 4'b1111, 4'b0110 back-to-back -> in_ready falls after the 2nd push, the 3rd is held off, out_y stays 4'b0111. Then out_ready=1 -> out_y gives 4'b0111 then 4'b1111, then the 3rd push is accepted.
- Push cout=1, in_flag_we=1, then push with in_flag_we=0 and cout=0 -> carry_q=1 after the first push and remains 1.
- clr_status with a flag-writing push of N=1,Z=0,C=1,V=1 in the same cycle -> status_nzcv=4'b1011. A clr_status alone in the next cycle -> 4'b0000.
- Buffer full (count=2) with rst_n pulsed low asynchronously mid-cycle -> out_valid=0, in_ready=1 and status_nzcv=0 immediately, without waiting for clk.
- With ALU_STICKY_OVERFLOW_EN defined: push V=1, then push V=0 -> status V=0 and ov_sticky=1. clr_status -> ov_sticky=0.
